// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweeper.
package tt_pkg;

   localparam int unsigned TT_IN_W    = 3;
   localparam int unsigned TT_TABLE_W = 8;

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StSample,
      StDone
   } tt_state_e;

   // Vector 000 lands in the MSB so the table reads like the gate's hex name.
   function automatic logic [TT_IN_W-1:0] tt_bit_pos(input logic [TT_IN_W-1:0] k);
      return 3'd7 - k;
   endfunction

endpackage

// File: rtl/tt_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset.
module tt_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/tt_sweep.sv
// Truth-table sweeper for 3-input gate models: drives all eight vectors and packs the results.
// Define TT_SWEEP_SYNC_EN to pass dut_out through a 2-flop synchronizer (settle grows by 2).
module tt_sweep
   import tt_pkg::*;
#(
   parameter int unsigned               SETTLE_CYCLES = 4,
   parameter logic [TT_TABLE_W-1:0]     EXPECTED      = 8'hBE
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  dut_out,
   output logic                  in1,
   output logic                  in2,
   output logic                  in3,
   output logic                  busy,
   output logic                  done,
   output logic [TT_TABLE_W-1:0] table_out,
   output logic                  match
);

   logic dut_smp;

`ifdef TT_SWEEP_SYNC_EN
   localparam int unsigned SYNC_EXTRA = 2;

   tt_sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (dut_out),
      .q     (dut_smp)
   );
`else
   localparam int unsigned SYNC_EXTRA = 0;

   assign dut_smp = dut_out;
`endif

   localparam int unsigned SETTLE_LEN = SETTLE_CYCLES + SYNC_EXTRA;
   localparam int unsigned CNT_W      = (SETTLE_LEN > 1) ? $clog2(SETTLE_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_LEN - 1);

   if (SETTLE_CYCLES < 1) begin : g_settle_chk
      $error("tt_sweep: SETTLE_CYCLES must be at least 1");
   end

   tt_state_e              state_q, state_d;
   logic [TT_IN_W-1:0]     k_q, k_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [TT_TABLE_W-1:0]  table_q, table_d;
   logic                   match_q, match_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         k_q     <= '0;
         cnt_q   <= '0;
         table_q <= '0;
         match_q <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         table_q <= table_d;
         match_q <= match_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (start) state_d = StSettle;
         StSettle: if (cnt_q == CNT_LAST) state_d = StSample;
         StSample: state_d = (k_q == 3'd7) ? StDone : StSettle;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      k_d     = k_q;
      cnt_d   = cnt_q;
      table_d = table_q;
      match_d = match_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               k_d     = '0;
               cnt_d   = '0;
               table_d = '0;
               match_d = 1'b0;
            end
         end
         StSettle: begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
         end
         StSample: begin
            table_d[tt_bit_pos(k_q)] = dut_smp;
            // Last vector: return the drive to 000 and latch the verdict for the DONE cycle.
            if (k_q == 3'd7) begin
               k_d     = '0;
               match_d = (table_d == EXPECTED);
            end else begin
               k_d = k_q + 3'd1;
            end
         end
         StDone:  k_d = '0;
         default: k_d = '0;
      endcase
   end

   always_comb begin
      busy            = (state_q == StSettle) || (state_q == StSample);
      done            = (state_q == StDone);
      {in1, in2, in3} = k_q;
      table_out       = table_q;
      match           = match_q;
   end

endmodule

// File: tb/tb_tt_sweep.sv
// Bench for tt_sweep: cycle-count model of the sweep checked every cycle, plus literal spot checks.
module tb_tt_sweep;

   localparam int unsigned S0 = 4;
   localparam int unsigned S1 = 1;
`ifdef TT_SWEEP_SYNC_EN
   localparam int EXTRA  = 2;
   localparam int DONE0  = 57;
   localparam int DONE1  = 33;
   localparam int VA_CYC = 4;
   localparam int VB_CYC = 5;
   localparam int VC_CYC = 32;
`else
   localparam int EXTRA  = 0;
   localparam int DONE0  = 41;
   localparam int DONE1  = 17;
   localparam int VA_CYC = 2;
   localparam int VB_CYC = 3;
   localparam int VC_CYC = 16;
`endif
   localparam int P0 = S0 + 1 + EXTRA;
   localparam int P1 = S1 + 1 + EXTRA;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] start = 2'b00;
   logic [1:0] dut_out, in1, in2, in3, busy, done, match;
   logic [7:0] tbl [2];
   int         kind [2];

   int n_vec = 0;
   int n_err = 0;

   int         c [2];
   logic       res_valid [2];
   logic [7:0] exp_tbl [2];
   int         ndone [2];
   logic [2:0] vec_log [0:255];

   always #5 clk = ~clk;

   // Gate kinds: 0 = 0xBE gate, 1 = constant 1, 2 = 0x1C gate.
   function automatic logic gate_fn(input int kd, input logic a, input logic b, input logic cc);
      case (kd)
         0:       return !(cc && (a == b));
         1:       return 1'b1;
         default: return (!a && b && cc) || (a && !b);
      endcase
   endfunction

   function automatic logic [7:0] model_table(input int kd);
      logic [7:0] t;
      logic [2:0] k;
      t = '0;
      for (int v = 0; v < 8; v++) begin
         k = 3'(v);
         t[7-v] = gate_fn(kd, k[2], k[1], k[0]);
      end
      return t;
   endfunction

   function automatic int per(input int i);
      return (i == 0) ? P0 : P1;
   endfunction

   assign dut_out[0] = gate_fn(kind[0], in1[0], in2[0], in3[0]);
   assign dut_out[1] = gate_fn(kind[1], in1[1], in2[1], in3[1]);

   tt_sweep #(.SETTLE_CYCLES(S0), .EXPECTED(8'hBE)) u_dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start[0]),
      .dut_out   (dut_out[0]),
      .in1       (in1[0]),
      .in2       (in2[0]),
      .in3       (in3[0]),
      .busy      (busy[0]),
      .done      (done[0]),
      .table_out (tbl[0]),
      .match     (match[0])
   );

   tt_sweep #(.SETTLE_CYCLES(S1), .EXPECTED(8'hBE)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start[1]),
      .dut_out   (dut_out[1]),
      .in1       (in1[1]),
      .in2       (in2[1]),
      .in3       (in3[1]),
      .busy      (busy[1]),
      .done      (done[1]),
      .table_out (tbl[1]),
      .match     (match[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: c counts cycles since start was accepted (1 = first drive cycle).
   always @(posedge clk or negedge rst_n) begin : model
      int last;
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            c[i]         = 0;
            res_valid[i] = 1'b0;
            exp_tbl[i]   = 8'h00;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            last = 8 * per(i) + 1;
            if ((c[i] == 0 || c[i] > last) && start[i]) begin
               c[i]         = 1;
               res_valid[i] = 1'b0;
               exp_tbl[i]   = model_table(kind[i]);
            end else if (c[i] != 0) begin
               c[i]++;
               if (c[i] == last) res_valid[i] = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin : compare
      int         p;
      logic       eb, ed, em;
      logic [2:0] ev;
      logic [7:0] et;
      if (rst_n) begin
         for (int i = 0; i < 2; i++) begin
            p  = per(i);
            eb = (c[i] >= 1) && (c[i] <= 8 * p);
            ed = (c[i] == 8 * p + 1);
            ev = eb ? 3'((c[i] - 1) / p) : 3'd0;
            em = res_valid[i] ? (exp_tbl[i] == 8'hBE) : 1'b0;
            et = res_valid[i] ? exp_tbl[i] : 8'h00;
            check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(eb));
            check($sformatf("done[%0d]", i), 32'(done[i]), 32'(ed));
            check($sformatf("vec[%0d]", i), 32'({in1[i], in2[i], in3[i]}), 32'(ev));
            check($sformatf("match[%0d]", i), 32'(match[i]), 32'(em));
            if (!eb) check($sformatf("table[%0d]", i), 32'(tbl[i]), 32'(et));
            if (done[i] === 1'b1) ndone[i]++;
         end
      end
   end

   task automatic run_sweep(input int i, output int cyc);
      @(negedge clk);
      start[i] = 1'b1;
      @(negedge clk);
      start[i] = 1'b0;
      cyc = 1;
      vec_log[1] = {in1[i], in2[i], in3[i]};
      while (done[i] !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         vec_log[cyc] = {in1[i], in2[i], in3[i]};
      end
      check($sformatf("done_seen[%0d]", i), 32'(done[i]), 32'd1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int cyc;
      int d0;
      int first_done;
      kind[0] = 0;
      kind[1] = 0;
      ndone[0] = 0;
      ndone[1] = 0;
      #12;
      for (int i = 0; i < 2; i++) begin
         check("rst_busy", 32'(busy[i]), 32'd0);
         check("rst_done", 32'(done[i]), 32'd0);
         check("rst_vec", 32'({in1[i], in2[i], in3[i]}), 32'd0);
         check("rst_table", 32'(tbl[i]), 32'h00);
         check("rst_match", 32'(match[i]), 32'd0);
      end
      @(negedge clk);
      #2 rst_n = 1'b1;

      // 0xBE gate, default settle
      run_sweep(0, cyc);
      check("be_done_cycle", 32'(cyc), 32'(DONE0));
      check("be_table", 32'(tbl[0]), 32'hBE);
      check("be_match", 32'(match[0]), 32'd1);

      // Constant-1 gate
      kind[0] = 1;
      run_sweep(0, cyc);
      check("ff_done_cycle", 32'(cyc), 32'(DONE0));
      check("ff_table", 32'(tbl[0]), 32'hFF);
      check("ff_match", 32'(match[0]), 32'd0);

      // S = 1 with a 0x1C gate, inputs monitored
      kind[1] = 2;
      run_sweep(1, cyc);
      check("s1_done_cycle", 32'(cyc), 32'(DONE1));
      check("s1_vec_a", 32'(vec_log[VA_CYC]), 32'd0);
      check("s1_vec_b", 32'(vec_log[VB_CYC]), 32'd1);
      check("s1_vec_c", 32'(vec_log[VC_CYC]), 32'd7);
      check("s1_vec_done", 32'(vec_log[DONE1]), 32'd0);
      check("s1_table", 32'(tbl[1]), 32'h1C);
      check("s1_match", 32'(match[1]), 32'd0);

      // Asynchronous reset at cycle 20 of a sweep
      kind[0] = 0;
      @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (19) @(negedge clk);
      d0 = ndone[0];
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy[0]), 32'd0);
      check("arst_done", 32'(done[0]), 32'd0);
      check("arst_vec", 32'({in1[0], in2[0], in3[0]}), 32'd0);
      check("arst_table", 32'(tbl[0]), 32'h00);
      check("arst_match", 32'(match[0]), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (60) @(negedge clk);
      check("arst_no_done", 32'(ndone[0] - d0), 32'd0);
      run_sweep(0, cyc);
      check("arst_fresh_table", 32'(tbl[0]), 32'hBE);
      check("arst_fresh_match", 32'(match[0]), 32'd1);

      // start pulsed mid-sweep and on the done cycle: both ignored
      @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      d0 = ndone[0];
      first_done = 0;
      for (int cy = 1; cy <= DONE0 + 10; cy++) begin
         start[0] = (cy == 5 || cy == DONE0) ? 1'b1 : 1'b0;
         if (done[0] === 1'b1 && first_done == 0) first_done = cy;
         @(negedge clk);
      end
      start[0] = 1'b0;
      check("ign_first_done", 32'(first_done), 32'(DONE0));
      check("ign_one_done", 32'(ndone[0] - d0), 32'd1);
      check("ign_idle_after", 32'(busy[0]), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
